// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types and constants for the register-file port controller.
// Select codes address the three registers; SEL_INV reads as zero.
package regfile_port_ctrl_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] SEL_R0  = 2'b00;
  localparam logic [1:0] SEL_R1  = 2'b01;
  localparam logic [1:0] SEL_R2  = 2'b10;
  localparam logic [1:0] SEL_INV = 2'b11;

  typedef struct packed {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/regfile_port_ctrl_sync_fifo.sv
// Write-request queue; exposes every slot's valid bit and select so
// the arbiter can see pending writes to the register being read.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [1:0]            i_sel,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [1:0]            o_head_sel,
  output logic [DATA_W-1:0]     o_head_data,
  output logic [DEPTH-1:0]      o_vld,
  output logic [DEPTH-1:0][1:0] o_sel
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][1:0]        r_sel;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [DEPTH-1:0]             r_vld;
  logic [AW-1:0]                r_wp;
  logic [AW-1:0]                r_rp;
  logic [CW-1:0]                r_cnt;

  logic                         w_push;
  logic                         w_pop;
  logic [DEPTH-1:0]             w_vld_nxt;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_comb begin
    w_vld_nxt = r_vld;
    if (w_pop)
      w_vld_nxt[r_rp] = 1'b0;
    if (w_push)
      w_vld_nxt[r_wp] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Payload needs no reset; slot validity is tracked in r_vld.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sel[r_wp]  <= i_sel;
      r_data[r_wp] <= i_data;
    end
  end

  assign o_count     = r_cnt;
  assign o_head_sel  = r_sel[r_rp];
  assign o_head_data = r_data[r_rp];
  assign o_vld       = r_vld;
  assign o_sel       = r_sel;

endmodule

// File: rtl/regfile_port_ctrl.sv
// Arbitrates reads and queued writes onto the single register-file port.
// Reads win unless they hit a pending write or have starved the queue.
module regfile_port_ctrl #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = regfile_port_ctrl_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [1:0]             wr_sel,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [1:0]             rd_sel,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rf_write,
  output logic [1:0]             rf_sel,
  output logic [DATA_W-1:0]      rf_data,
  input  logic [DATA_W-1:0]      rf_selected,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drop_err
);

  import regfile_port_ctrl_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                    w_full;
  logic                    w_empty;
  logic [1:0]              w_head_sel;
  logic [DATA_W-1:0]       w_head_data;
  logic [DEPTH-1:0]        w_vld;
  logic [DEPTH-1:0][1:0]   w_qsel;
  logic                    w_hazard;
  logic                    w_starved;
  logic                    w_rd_go;
  logic                    w_drain;
  logic                    w_wr_hs;
  logic                    w_push;
  logic                    w_drop;

  logic [SW-1:0]           r_starve;
  logic                    r_rsp_valid;
  logic [DATA_W-1:0]       r_rsp_data;
  logic                    r_drop;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_sel       (wr_sel),
    .i_data      (wr_data),
    .i_pop       (w_drain),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count),
    .o_head_sel  (w_head_sel),
    .o_head_data (w_head_data),
    .o_vld       (w_vld),
    .o_sel       (w_qsel)
  );

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (w_vld[i] && (w_qsel[i] == rd_sel))
        w_hazard = 1'b1;
  end

  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign wr_ready  = ~rst & ~w_full;
  assign rd_ready  = ~rst & ~w_hazard & ~w_starved;
  assign w_rd_go   = rd_valid & rd_ready;
  assign w_drain   = ~rst & ~w_rd_go & ~w_empty;
  assign w_wr_hs   = wr_valid & wr_ready;
  assign w_push    = w_wr_hs & (wr_sel != SEL_INV);
  assign w_drop    = w_wr_hs & (wr_sel == SEL_INV);

  always_comb begin
    rf_write = 1'b0;
    rf_sel   = SEL_R0;
    rf_data  = '0;
    unique case (1'b1)
      w_rd_go: begin
        rf_sel = rd_sel;
      end
      w_drain: begin
        rf_write = 1'b1;
        rf_sel   = w_head_sel;
        rf_data  = w_head_data;
      end
      default: ;
    endcase
  end

  // Counts reads that bypassed a non-empty queue.
  always_ff @(posedge clk) begin
    if (rst)
      r_starve <= '0;
    else if (w_drain || w_empty)
      r_starve <= '0;
    else if (w_rd_go)
      r_starve <= r_starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd_go;
      r_drop      <= w_drop;
      if (w_rd_go)
        r_rsp_data <= rf_selected;
    end
  end

  // An in-flight response is squashed by a reset arriving in its cycle.
  assign rsp_valid = r_rsp_valid & ~rst;
  assign rsp_data  = r_rsp_data;
  assign drop_err  = r_drop;

endmodule
